power_lut_arbiter: RTL and testbench

- Controller that shares one external single-port power-law LUT (256 x 16, 1.15 fixed-point, e.g. x^0.7 transmission table) between NREQ pixel-channel requesters (R, G, B).
- Round-robin arbitration issues one lookup per cycle, and responses return one cycle after acceptance.
- A config path reloads the whole table at runtime when beta changes, for example x^0.7 to x^0.3. During a reload, lookups are held off.
- Sits between the per-channel dehazing datapaths and the LUT memory.

---
 rtl/power_lut_arbiter.sv | 132 +++++++++++++
 tb/tb_power_lut_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_lut_arbiter.sv
// Shares one single-port power-law LUT between NREQ pixel-channel requesters.
// Round-robin lookups with 1-cycle latency; a config path reloads the whole table.
module power_lut_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ADDR_W-1:0]      lut_addr,
  output logic                   lut_we,
  output logic [DATA_W-1:0]      lut_wdata,
  input  logic [DATA_W-1:0]      lut_rdata,
  input  logic                   cfg_start,
  input  logic                   cfg_wr_valid,
  input  logic [DATA_W-1:0]      cfg_wr_data,
  output logic                   cfg_wr_ready,
  output logic                   cfg_busy,
  output logic                   cfg_done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'((1 << ADDR_W) - 1);

  typedef enum logic [1:0] {SERVE, DRAIN, LOAD} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, win;
  logic              found;
  int                cand;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              done_nxt;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0] data_q;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = PTR_W'(cand);
      end
    end
  end

  // Next-state and LUT port control; outputs held quiet while in reset.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    done_nxt     = 1'b0;
    grant        = '0;
    lut_addr     = '0;
    lut_we       = 1'b0;
    lut_wdata    = '0;
    cfg_wr_ready = 1'b0;
    unique case (state)
      SERVE: begin
        if (cfg_start) begin
          state_nxt = DRAIN;
        end else if (found) begin
          grant[win] = 1'b1;
          lut_addr   = req_addr[win*ADDR_W +: ADDR_W];
          ptr_nxt    = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      DRAIN: begin
        state_nxt = LOAD;
        cnt_nxt   = '0;
      end
      LOAD: begin
        cfg_wr_ready = 1'b1;
        if (cfg_wr_valid) begin
          lut_we    = 1'b1;
          lut_addr  = cnt[ADDR_W-1:0];
          lut_wdata = cfg_wr_data;
          cnt_nxt   = cnt + 1'b1;
          if (cnt == LAST_WORD) begin
            state_nxt = SERVE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = SERVE;
    endcase
    if (!rst_n) begin
      grant        = '0;
      lut_addr     = '0;
      lut_we       = 1'b0;
      lut_wdata    = '0;
      cfg_wr_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SERVE;
      ptr         <= '0;
      cnt         <= '0;
      rsp_valid_q <= '0;
      data_q      <= '0;
      cfg_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      rsp_valid_q <= grant;
      cfg_done    <= done_nxt;
      if (|rsp_valid_q) data_q <= lut_rdata;
    end
  end

  // LUT read data is already registered, so the response passes it straight through.
  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = (|rsp_valid_q) ? lut_rdata : data_q;
  assign cfg_busy  = (state != SERVE);

endmodule

// File: tb/tb_power_lut_arbiter.sv
// Directed bench for power_lut_arbiter with a registered-read 256x16 LUT model
// preloaded with round((x/255)^0.7 * 2^15).
module tb_power_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_addr;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [7:0]  lut_addr;
  logic        lut_we;
  logic [15:0] lut_wdata;
  logic [15:0] lut_rdata;
  logic        cfg_start;
  logic        cfg_wr_valid;
  logic [15:0] cfg_wr_data;
  logic        cfg_wr_ready;
  logic        cfg_busy;
  logic        cfg_done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int busy_grant_err = 0;

  logic [15:0] mem [256];
  bit          seeded = 1'b0;

  logic [2:0]  v;
  int          waitc [3];
  int          maxwait;

  power_lut_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .lut_addr(lut_addr), .lut_we(lut_we), .lut_wdata(lut_wdata), .lut_rdata(lut_rdata),
    .cfg_start(cfg_start), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ready(cfg_wr_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  function automatic int pw(int a, real beta);
    real x;
    x = a / 255.0;
    return int'($floor($pow(x, beta) * 32768.0 + 0.5));
  endfunction

  function automatic logic [7:0] addr_of(int j, int i);
    return 8'((j * 40 + i * 13 + 5) % 256);
  endfunction

  // Single-port LUT with registered read, seeded with the x^0.7 table.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'(pw(k, 0.7));
      seeded <= 1'b1;
    end else if (lut_we) begin
      mem[lut_addr] <= lut_wdata;
    end
    lut_rdata <= mem[lut_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_done) done_cnt++;
      if (cfg_busy && req_ready != 3'b000) busy_grant_err++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] valid, input logic [7:0] a0,
                                input logic [7:0] a1, input logic [7:0] a2,
                                input logic start);
    req_valid = valid;
    req_addr  = {a2, a1, a0};
    cfg_start = start;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_errs(real beta);
    int e = 0;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== 16'(pw(k, beta))) e++;
    return e;
  endfunction

  // Streams nwords table words with random gaps, optionally pulsing cfg_start at word restart_at.
  task automatic load_table(input real beta, input int nwords, input int restart_at);
    int bad = 0;
    int gap;
    for (int k = 0; k < nwords; k++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        cfg_wr_valid = 1'b0;
        #1;
        if (lut_we !== 1'b0 || cfg_busy !== 1'b1 || cfg_wr_ready !== 1'b1 ||
            req_ready !== 3'b000 || cfg_done !== 1'b0) bad++;
        cyc();
      end
      cfg_wr_valid = 1'b1;
      cfg_wr_data  = 16'(pw(k, beta));
      cfg_start    = (k == restart_at);
      #1;
      if (lut_we !== 1'b1 || lut_addr !== 8'(k) || lut_wdata !== cfg_wr_data ||
          cfg_busy !== 1'b1 || cfg_wr_ready !== 1'b1 || req_ready !== 3'b000 ||
          cfg_done !== 1'b0) bad++;
      cyc();
      cfg_start = 1'b0;
    end
    cfg_wr_valid = 1'b0;
    check_output("load_words", bad, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    cfg_wr_valid = 1'b0;
    cfg_wr_data  = '0;
    apply_stimulus(3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_lut_we", lut_we, 0);
    check_output("rst_lut_wdata", lut_wdata, 0);
    check_output("rst_lut_addr", lut_addr, 0);
    check_output("rst_cfg_done", cfg_done, 0);
    check_output("rst_cfg_busy", cfg_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    $display("[TB] single requester lookups");
    apply_stimulus(3'b001, 8'd255, 8'd0, 8'd0, 1'b0);
    #1;
    check_output("single_ready0", req_ready, 3'b001);
    check_output("single_addr0", lut_addr, 8'd255);
    check_output("single_we", lut_we, 0);
    cyc();
    apply_stimulus(3'b001, 8'd0, 8'd0, 8'd0, 1'b0);
    #1;
    check_output("single_rspv0", rsp_valid, 3'b001);
    check_output("single_rspd0", rsp_data, 16'h8000);
    check_output("single_ready1", req_ready, 3'b001);
    check_output("single_addr1", lut_addr, 8'd0);
    cyc();
    apply_stimulus(3'b100, 8'd0, 8'd0, 8'd7, 1'b0);
    #1;
    check_output("single_rspv1", rsp_valid, 3'b001);
    check_output("single_rspd1", rsp_data, 16'h0000);
    check_output("align_ready", req_ready, 3'b100);
    cyc();

    $display("[TB] all three requesters streaming");
    for (int j = 0; j < 6; j++) begin
      apply_stimulus(3'b111, addr_of(j, 0), addr_of(j, 1), addr_of(j, 2), 1'b0);
      #1;
      check_output("rr_ready", req_ready, 3'b001 << (j % 3));
      check_output("rr_addr", lut_addr, addr_of(j, j % 3));
      if (j > 0) begin
        check_output("rr_rspv", rsp_valid, 3'b001 << ((j - 1) % 3));
        check_output("rr_rspd", rsp_data, pw(addr_of(j - 1, (j - 1) % 3), 0.7));
      end
      cyc();
    end
    apply_stimulus(3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
    #1;
    check_output("rr_rspv_last", rsp_valid, 3'b100);
    check_output("rr_rspd_last", rsp_data, pw(addr_of(5, 2), 0.7));
    cyc();
    check_output("hold_rspv", rsp_valid, 3'b000);
    check_output("hold_rspd", rsp_data, pw(addr_of(5, 2), 0.7));

    $display("[TB] pointer fairness");
    apply_stimulus(3'b010, 8'd1, 8'd2, 8'd3, 1'b0);
    #1;
    check_output("fair_r1", req_ready, 3'b010);
    cyc();
    apply_stimulus(3'b101, 8'd1, 8'd2, 8'd3, 1'b0);
    #1;
    check_output("fair_r2", req_ready, 3'b100);
    cyc();
    apply_stimulus(3'b101, 8'd1, 8'd2, 8'd3, 1'b0);
    #1;
    check_output("fair_r0", req_ready, 3'b001);
    cyc();

    v       = 3'b000;
    maxwait = 0;
    for (int i = 0; i < 3; i++) waitc[i] = 0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < 3; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i]     = 1'b1;
          waitc[i] = 0;
        end
      apply_stimulus(v, 8'(c), 8'(c + 1), 8'(c + 2), 1'b0);
      #1;
      check_output("rr_legal", 32'(((req_ready & ~v) == 3'b000) && $onehot0(req_ready) &&
                                  ((v == 3'b000) || (req_ready != 3'b000))), 1);
      for (int i = 0; i < 3; i++) begin
        if (req_ready[i]) v[i] = 1'b0;
        else if (v[i]) begin
          waitc[i]++;
          if (waitc[i] > maxwait) maxwait = waitc[i];
        end
      end
      cyc();
    end
    check_output("no_starve", 32'(maxwait <= 2), 1);
    apply_stimulus(3'b100, 8'd0, 8'd0, 8'd0, 1'b0);
    #1;
    check_output("realign_ready", req_ready, 3'b100);
    cyc();

    $display("[TB] reload during streaming");
    apply_stimulus(3'b111, 8'd11, 8'd22, 8'd33, 1'b0);
    #1;
    check_output("pre_cfg_ready", req_ready, 3'b001);
    cyc();
    apply_stimulus(3'b111, 8'd11, 8'd22, 8'd33, 1'b1);
    #1;
    check_output("start_ready", req_ready, 3'b000);
    check_output("start_rspv", rsp_valid, 3'b001);
    check_output("start_rspd", rsp_data, pw(11, 0.7));
    check_output("start_busy", cfg_busy, 0);
    cyc();
    apply_stimulus(3'b111, 8'd11, 8'd22, 8'd33, 1'b0);
    #1;
    check_output("drain_busy", cfg_busy, 1);
    check_output("drain_ready", req_ready, 3'b000);
    check_output("drain_rspv", rsp_valid, 3'b000);
    check_output("drain_wr_ready", cfg_wr_ready, 0);
    check_output("drain_we", lut_we, 0);
    cyc();
    load_table(0.3, 256, -1);
    apply_stimulus(3'b111, 8'd11, 8'd128, 8'd33, 1'b0);
    #1;
    check_output("done_pulse", cfg_done, 1);
    check_output("done_busy", cfg_busy, 0);
    check_output("done_ready", req_ready, 3'b010);
    check_output("done_addr", lut_addr, 8'd128);
    cyc();
    apply_stimulus(3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
    #1;
    check_output("x03_rspv", rsp_valid, 3'b010);
    check_output("x03_rspd", rsp_data, pw(128, 0.3));
    check_output("done_clear", cfg_done, 0);
    check_output("done_count1", done_cnt, 1);
    check_output("mem_x03", mem_errs(0.3), 0);

    $display("[TB] reset in the middle of a load");
    apply_stimulus(3'b000, 8'd0, 8'd0, 8'd0, 1'b1);
    cyc();
    cfg_start = 1'b0;
    cyc();
    load_table(0.7, 100, -1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", cfg_busy, 0);
    check_output("mid_rst_we", lut_we, 0);
    check_output("mid_rst_addr", lut_addr, 0);
    check_output("mid_rst_wdata", lut_wdata, 0);
    check_output("mid_rst_rspv", rsp_valid, 0);
    check_output("mid_rst_rspd", rsp_data, 0);
    check_output("mid_rst_done", cfg_done, 0);
    check_output("mid_rst_wr_ready", cfg_wr_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    check_output("post_rst_busy", cfg_busy, 0);
    apply_stimulus(3'b000, 8'd0, 8'd0, 8'd0, 1'b1);
    cyc();
    cfg_start = 1'b0;
    cyc();
    load_table(0.7, 256, -1);
    check_output("fresh_done", cfg_done, 1);
    check_output("mem_x07", mem_errs(0.7), 0);
    cyc();
    check_output("done_count2", done_cnt, 2);

    $display("[TB] cfg_start during load is ignored");
    apply_stimulus(3'b000, 8'd0, 8'd0, 8'd0, 1'b1);
    cyc();
    cfg_start = 1'b0;
    cyc();
    load_table(0.3, 256, 50);
    check_output("restart_done", cfg_done, 1);
    check_output("restart_busy", cfg_busy, 0);
    check_output("mem_x03_again", mem_errs(0.3), 0);
    cyc();
    check_output("restart_done_clear", cfg_done, 0);
    check_output("done_count3", done_cnt, 3);
    check_output("busy_no_grant", busy_grant_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
